// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider and its restoring-step datapath.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  // Iteration counter width; a 1-bit counter still works for the smallest WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, compare, conditionally subtract.
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] trial;
  logic           fits;
  logic           unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit never carries information.
  assign unused_rem_msb = rem_in[WIDTH];

  always_comb begin
    trial   = {rem_in[WIDTH-1:0], q_in[WIDTH-1]};
    fits    = (trial >= {1'b0, divisor});
    rem_out = fits ? (trial - {1'b0, divisor}) : trial;
    q_out   = {q_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with start/done handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_t       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_q;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .q_in    (q_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    q_d         = q_q;
    rem_d       = rem_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            state_d   = RUN;
            divisor_d = divisor;
            q_d       = dividend;
            rem_d     = '0;
            count_d   = CntW'(WIDTH - 1);
            dbz_d     = 1'b0;
          end else begin
            // Divide-by-zero skips the datapath and reports saturated results immediately.
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end
        end
      end
      RUN: begin
        q_d     = step_q;
        rem_d   = step_rem;
        count_d = count_q - CntW'(1);
        if (count_q == '0) begin
          state_d     = DONE;
          quotient_d  = step_q;
          remainder_d = step_rem[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      q_q         <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      q_q         <= q_d;
      rem_q       <= rem_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at WIDTH=4.
module tb_seq_divider;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Drives start for one cycle right after an edge and watches the next 12 edges.
  // lat is the number of edges from the driving edge to the first cycle with done high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                       output int dones, output logic busy1, output logic busy_after);
    lat        = -1;
    dones      = 0;
    busy1      = 1'b0;
    busy_after = 1'b1;
    @(posedge clk);
    #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (e == 1) busy1 = busy;
      if (lat >= 0 && e == lat + 1) busy_after = busy;
      if (done) begin
        dones++;
        if (lat < 0) lat = e;
      end
    end
  endtask

  initial begin
    int          lat;
    int          dones;
    logic        busy1;
    logic        busy_after;
    logic [W-1:0] held_q;

    vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
    vecs[2] = '{4'd7,  4'd9,  4'd0,  4'd7,  1'b0};
    vecs[3] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
    vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0};
    vecs[5] = '{4'd10, 4'd0,  4'd15, 4'd10, 1'b1};
    vecs[6] = '{4'd9,  4'd4,  4'd2,  4'd1,  1'b0};
    vecs[7] = '{4'd14, 4'd3,  4'd4,  4'd2,  1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset dbz", int'(div_by_zero), 0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat, dones, busy1, busy_after);
      check($sformatf("vec%0d quotient", i), int'(quotient), int'(vecs[i].q));
      check($sformatf("vec%0d remainder", i), int'(remainder), int'(vecs[i].r));
      check($sformatf("vec%0d dbz", i), int'(div_by_zero), int'(vecs[i].dbz));
      check($sformatf("vec%0d latency", i), lat, vecs[i].dbz ? 1 : 5);
      check($sformatf("vec%0d done count", i), dones, 1);
      check($sformatf("vec%0d busy after start", i), int'(busy1), 1);
      check($sformatf("vec%0d busy after done", i), int'(busy_after), 0);
    end

    // Results must hold while idle even when operands wiggle.
    held_q   = quotient;
    dividend = 4'd1;
    divisor  = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    check("hold quotient idle", int'(quotient), int'(held_q));
    check("hold remainder idle", int'(remainder), 2);

    // Second start during RUN with different operands must be ignored.
    dones = 0;
    @(posedge clk);
    #1;
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (e == 2) begin
        dividend = 4'd3;
        divisor  = 4'd1;
        start    = 1'b1;
      end
      if (done) dones++;
    end
    check("ignored start quotient", int'(quotient), 2);
    check("ignored start remainder", int'(remainder), 2);
    check("ignored start done count", dones, 1);

    // Reset in RUN cycle 2 abandons the operation without a done pulse.
    dones = 0;
    @(posedge clk);
    #1;
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = (e == 2);
      if (e == 3) begin
        check("mid-run reset busy", int'(busy), 0);
        check("mid-run reset quotient", int'(quotient), 0);
        check("mid-run reset remainder", int'(remainder), 0);
        check("mid-run reset dbz", int'(div_by_zero), 0);
      end
      if (done) dones++;
    end
    check("mid-run reset done count", dones, 0);
    do_op(4'd14, 4'd3, lat, dones, busy1, busy_after);
    check("after reset quotient", int'(quotient), 4);
    check("after reset remainder", int'(remainder), 2);
    check("after reset done count", dones, 1);

    // Exhaustive sweep against a behavioural model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(W'(a), W'(b), lat, dones, busy1, busy_after);
        check($sformatf("sweep %0d/%0d quotient", a, b), int'(quotient), (b == 0) ? 15 : a / b);
        check($sformatf("sweep %0d/%0d remainder", a, b), int'(remainder), (b == 0) ? a : a % b);
        check($sformatf("sweep %0d/%0d dbz", a, b), int'(div_by_zero), (b == 0) ? 1 : 0);
        check($sformatf("sweep %0d/%0d done count", a, b), dones, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
